// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: bundles the IDU-side op input, the CSR file port and the WBU result port.
//  master: the controller (drives in_ready, csr_* requests, out_* results)
//  slave : the surrounding pipeline and CSR file
interface csr_access_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_csr_addr;
    logic [XLEN-1:0]   in_src;
    logic [4:0]        in_rs1_idx;
    logic [4:0]        in_rd;
    logic [XLEN-1:0]   in_pc;
    logic [ADDR_W-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_wen;
    logic [ADDR_W-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_ecall;
    logic              csr_mret;
    logic [XLEN-1:0]   csr_pc;
    logic [XLEN-1:0]   csr_mtvec;
    logic [XLEN-1:0]   csr_mepc;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rd;
    logic              out_rd_wen;
    logic [XLEN-1:0]   out_rd_wdata;
    logic              out_redirect;
    logic [XLEN-1:0]   out_redirect_pc;
    logic              out_illegal;
    modport master (
        input  in_valid, in_op, in_csr_addr, in_src, in_rs1_idx, in_rd, in_pc,
               csr_rdata, csr_mtvec, csr_mepc, out_ready,
        output in_ready, csr_raddr, csr_wen, csr_waddr, csr_wdata, csr_ecall, csr_mret, csr_pc,
               out_valid, out_rd, out_rd_wen, out_rd_wdata, out_redirect, out_redirect_pc, out_illegal
    );
    modport slave (
        output in_valid, in_op, in_csr_addr, in_src, in_rs1_idx, in_rd, in_pc,
               csr_rdata, csr_mtvec, csr_mepc, out_ready,
        input  in_ready, csr_raddr, csr_wen, csr_waddr, csr_wdata, csr_ecall, csr_mret, csr_pc,
               out_valid, out_rd, out_rd_wen, out_rd_wdata, out_redirect, out_redirect_pc, out_illegal
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences one Zicsr read-modify-write or ecall/mret op against the CSR file.
//  clock, reset (async, active-low); bus: csr_access_ctrl_if master (op in, CSR port, WBU result out)
module csr_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input logic clock,
    input logic reset,
    csr_access_ctrl_if.master bus
);
    localparam logic [2:0] OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011, OP_ECALL = 3'b100, OP_MRET = 3'b101;
    typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, RESP} state_t;
    state_t            state;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   src, pc, old_v, new_v;
    logic [4:0]        rs1, rd;
    logic              we;
    always_comb begin
        new_v = op == OP_RW ? src : op == OP_RS ? (bus.csr_rdata | src) : (bus.csr_rdata & ~src);
        we    = op == OP_RW || rs1 != 5'd0;
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.csr_raddr = addr;
    assign bus.csr_waddr = addr;
    assign bus.csr_pc    = pc;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            op                  <= '0;
            addr                <= '0;
            src                 <= '0;
            pc                  <= '0;
            old_v               <= '0;
            rs1                 <= '0;
            rd                  <= '0;
            bus.csr_wen         <= 1'b0;
            bus.csr_wdata       <= '0;
            bus.csr_ecall       <= 1'b0;
            bus.csr_mret        <= 1'b0;
            bus.out_valid       <= 1'b0;
            bus.out_rd          <= '0;
            bus.out_rd_wen      <= 1'b0;
            bus.out_rd_wdata    <= '0;
            bus.out_redirect    <= 1'b0;
            bus.out_redirect_pc <= '0;
            bus.out_illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op         <= bus.in_op;
                    addr       <= bus.in_csr_addr;
                    src        <= bus.in_src;
                    rs1        <= bus.in_rs1_idx;
                    rd         <= bus.in_rd;
                    pc         <= bus.in_pc;
                    bus.out_rd <= bus.in_rd;
                    if (bus.in_op == OP_RW || bus.in_op == OP_RS || bus.in_op == OP_RC) state <= READ;
                    else if (bus.in_op == OP_ECALL || bus.in_op == OP_MRET) begin
                        bus.csr_ecall <= bus.in_op == OP_ECALL;
                        bus.csr_mret  <= bus.in_op == OP_MRET;
                        state         <= TRAP;
                    end else begin
                        bus.out_valid   <= 1'b1;
                        bus.out_illegal <= 1'b1;
                        state           <= RESP;
                    end
                end
                READ: begin
                    old_v <= bus.csr_rdata;
                    // writing a read-only CSR (addr[11:10]==11) is refused before any strobe
                    if (we && addr[ADDR_W-1 -: 2] == 2'b11) begin
                        bus.out_valid   <= 1'b1;
                        bus.out_illegal <= 1'b1;
                        state           <= RESP;
                    end else begin
                        bus.csr_wen   <= we;
                        bus.csr_wdata <= we ? new_v : '0;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    bus.csr_wen      <= 1'b0;
                    bus.csr_wdata    <= '0;
                    bus.out_valid    <= 1'b1;
                    bus.out_rd_wen   <= rd != 5'd0;
                    bus.out_rd_wdata <= old_v;
                    state            <= RESP;
                end
                TRAP: begin
                    bus.csr_ecall       <= 1'b0;
                    bus.csr_mret        <= 1'b0;
                    bus.out_redirect_pc <= op == OP_ECALL ? bus.csr_mtvec : bus.csr_mepc;
                    bus.out_redirect    <= 1'b1;
                    bus.out_valid       <= 1'b1;
                    state               <= RESP;
                end
                RESP: if (bus.out_ready) begin
                    bus.out_valid    <= 1'b0;
                    bus.out_rd_wen   <= 1'b0;
                    bus.out_redirect <= 1'b0;
                    bus.out_illegal  <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed self-checking bench for csr_access_ctrl.
module tb_csr_access_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    csr_access_ctrl_if #(.XLEN(32), .ADDR_W(12)) bus ();
    csr_access_ctrl #(.XLEN(32), .ADDR_W(12)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic offer(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] pc);
        bus.in_op       = op;
        bus.in_csr_addr = addr;
        bus.in_src      = src;
        bus.in_rs1_idx  = rs1;
        bus.in_rd       = rd;
        bus.in_pc       = pc;
        bus.in_valid    = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask
    initial begin
        bus.in_valid = 0; bus.in_op = 0; bus.in_csr_addr = 0; bus.in_src = 0;
        bus.in_rs1_idx = 0; bus.in_rd = 0; bus.in_pc = 0; bus.csr_rdata = 0;
        bus.csr_mtvec = 0; bus.csr_mepc = 0; bus.out_ready = 1;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_csr_wen", bus.csr_wen, 0);
        chk("rst_rd_wdata", bus.out_rd_wdata, 0);
        step();
        reset = 1;
        step();
        // 1: CSRRW 0x305
        bus.csr_rdata = 32'h0;
        offer(3'b001, 12'h305, 32'h80000100, 5'd1, 5'd5, 32'h0);
        chk("rw_in_ready_n1", bus.in_ready, 0);
        chk("rw_raddr", bus.csr_raddr, 12'h305);
        chk("rw_wen_n1", bus.csr_wen, 0);
        step();
        chk("rw_wen_n2", bus.csr_wen, 1);
        chk("rw_waddr", bus.csr_waddr, 12'h305);
        chk("rw_wdata", bus.csr_wdata, 32'h80000100);
        chk("rw_valid_n2", bus.out_valid, 0);
        step();
        chk("rw_wen_n3", bus.csr_wen, 0);
        chk("rw_wdata_n3", bus.csr_wdata, 0);
        chk("rw_valid_n3", bus.out_valid, 1);
        chk("rw_rd", bus.out_rd, 5);
        chk("rw_rd_wen", bus.out_rd_wen, 1);
        chk("rw_rd_wdata", bus.out_rd_wdata, 0);
        chk("rw_illegal", bus.out_illegal, 0);
        step();
        chk("rw_idle_valid", bus.out_valid, 0);
        chk("rw_idle_ready", bus.in_ready, 1);
        // 2: CSRRS with rs1_idx=0 reads only
        bus.csr_rdata = 32'h1800;
        offer(3'b010, 12'h300, 32'h0, 5'd0, 5'd3, 32'h0);
        step();
        chk("rs0_wen", bus.csr_wen, 0);
        chk("rs0_wdata", bus.csr_wdata, 0);
        step();
        chk("rs0_valid", bus.out_valid, 1);
        chk("rs0_rd_wdata", bus.out_rd_wdata, 32'h1800);
        chk("rs0_rd_wen", bus.out_rd_wen, 1);
        step();
        // CSRRS with rs1 nonzero sets bits
        bus.csr_rdata = 32'h1800;
        offer(3'b010, 12'h300, 32'h6, 5'd6, 5'd3, 32'h0);
        step();
        chk("rs_wen", bus.csr_wen, 1);
        chk("rs_wdata", bus.csr_wdata, 32'h1806);
        step();
        step();
        // 3: CSRRC clears bits, rd=0 suppresses rd write
        bus.csr_rdata = 32'h1888;
        offer(3'b011, 12'h300, 32'h8, 5'd8, 5'd0, 32'h0);
        step();
        chk("rc_wen", bus.csr_wen, 1);
        chk("rc_wdata", bus.csr_wdata, 32'h1880);
        step();
        chk("rc_valid", bus.out_valid, 1);
        chk("rc_rd_wen", bus.out_rd_wen, 0);
        chk("rc_rd_wdata", bus.out_rd_wdata, 32'h1888);
        step();
        // 4: ECALL
        bus.csr_mtvec = 32'h30000400;
        offer(3'b100, 12'h0, 32'h0, 5'd0, 5'd0, 32'h30000010);
        chk("ec_ecall_n1", bus.csr_ecall, 1);
        chk("ec_mret_n1", bus.csr_mret, 0);
        chk("ec_pc", bus.csr_pc, 32'h30000010);
        chk("ec_valid_n1", bus.out_valid, 0);
        step();
        chk("ec_ecall_n2", bus.csr_ecall, 0);
        chk("ec_valid_n2", bus.out_valid, 1);
        chk("ec_redirect", bus.out_redirect, 1);
        chk("ec_redirect_pc", bus.out_redirect_pc, 32'h30000400);
        chk("ec_rd_wen", bus.out_rd_wen, 0);
        step();
        chk("ec_redirect_clr", bus.out_redirect, 0);
        // MRET
        bus.csr_mepc = 32'h30000014;
        offer(3'b101, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0);
        chk("mr_mret_n1", bus.csr_mret, 1);
        chk("mr_ecall_n1", bus.csr_ecall, 0);
        step();
        chk("mr_mret_n2", bus.csr_mret, 0);
        chk("mr_redirect_pc", bus.out_redirect_pc, 32'h30000014);
        chk("mr_valid", bus.out_valid, 1);
        step();
        // 5: write to read-only CSR
        bus.csr_rdata = 32'h12;
        offer(3'b001, 12'hF11, 32'h55, 5'd1, 5'd4, 32'h0);
        step();
        chk("ro_wen", bus.csr_wen, 0);
        chk("ro_valid", bus.out_valid, 1);
        chk("ro_illegal", bus.out_illegal, 1);
        chk("ro_rd_wen", bus.out_rd_wen, 0);
        step();
        chk("ro_illegal_clr", bus.out_illegal, 0);
        // illegal op code
        offer(3'b111, 12'h300, 32'h0, 5'd0, 5'd2, 32'h0);
        chk("bad_valid_n1", bus.out_valid, 1);
        chk("bad_illegal", bus.out_illegal, 1);
        chk("bad_wen", bus.csr_wen, 0);
        step();
        chk("bad_idle", bus.in_ready, 1);
        // 6: back-pressure in RESP
        bus.out_ready = 0;
        bus.csr_rdata = 32'hABCD;
        offer(3'b001, 12'h340, 32'h77, 5'd1, 5'd9, 32'h0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1;
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_rd_wdata", bus.out_rd_wdata, 32'hABCD);
            chk("bp_rd", bus.out_rd, 9);
            chk("bp_in_ready", bus.in_ready, 0);
            step();
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        step();
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        // reset during WRITE
        offer(3'b001, 12'h340, 32'h99, 5'd1, 5'd9, 32'h0);
        step();
        chk("rw_mid_wen", bus.csr_wen, 1);
        reset = 0;
        #1;
        chk("rst_mid_wen", bus.csr_wen, 0);
        chk("rst_mid_ready", bus.in_ready, 1);
        step();
        reset = 1;
        step();
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_wen", bus.csr_wen, 0);
        step();
        chk("post_rst_valid", bus.out_valid, 0);
        chk("post_rst_wen2", bus.csr_wen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
